multicycle_adder: RTL

Parametrised multi-cycle ripple adder/subtractor built from a chain of SLICE one-bit full-adder cells. It processes a WIDTH-bit operand pair SLICE bits per clock and carries between slices through a registered carry. It generalises the single-bit CMOS full adder into a WIDTH-bit datapath with a start/done handshake, a subtract mode and signed-overflow detection. Arithmetic units that trade latency for area instantiate it.

---
 rtl/multicycle_adder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
//   Multi-cycle ripple adder/subtractor. A WIDTH-bit operand pair is summed
//   SLICE bits per clock through a chain of one-bit full-adder cells. The carry
//   between slices is held in a register. Subtract mode computes a + ~b + 1.
//   A start/done handshake frames each operation.
//
// Parameters
//   WIDTH    operand/result width (>= 1)
//   SLICE    bits added per clock; must divide WIDTH (N = WIDTH/SLICE cycles)
//
// Ports
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_start   request, sampled only while idle
//   i_a, i_b  operands, captured on an accepted start
//   i_cin     carry-in, captured on an accepted start (ignored when i_sub = 1)
//   i_sub     0: a+b+cin, 1: a-b
//   o_busy    operation in progress
//   o_done    one-cycle pulse when a result is valid
//   o_sum     result, held until the next completion
//   o_cout    carry out of the MSB (in subtract mode, 1 = no borrow)
//   o_ovf     two's-complement overflow
// -----------------------------------------------------------------------------
module multicycle_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;       // already inverted in subtract mode
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [SLICE-1:0] w_a_sl;
   logic [SLICE-1:0] w_b_sl;
   logic [SLICE-1:0] w_s;
   logic [SLICE:0]   w_c;       // w_c[i] is the carry into bit i of the slice
   logic [WIDTH-1:0] w_acc_next;

   assign w_a_sl = r_a[int'(r_cnt) * SLICE +: SLICE];
   assign w_b_sl = r_b[int'(r_cnt) * SLICE +: SLICE];
   assign w_c[0] = r_carry;

   // Ripple chain of one-bit full adders for the current slice
   for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
      assign w_s[gi]   = w_a_sl[gi] ^ w_b_sl[gi] ^ w_c[gi];
      assign w_c[gi+1] = (w_a_sl[gi] & w_b_sl[gi]) |
                         (w_c[gi] & (w_a_sl[gi] ^ w_b_sl[gi]));
   end

   // Accumulator with the current slice merged in; on the last slice this is
   // the complete result, so the sum can be loaded from it on the same edge.
   always_comb begin
      w_acc_next = r_acc;
      w_acc_next[int'(r_cnt) * SLICE +: SLICE] = w_s;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_sub ? ~i_b : i_b;
                  r_carry <= i_sub | i_cin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_acc   <= w_acc_next;
               r_carry <= w_c[SLICE];
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_sum   <= w_acc_next;
                  r_cout  <= w_c[SLICE];
                  // carry into the MSB vs carry out of the MSB
                  r_ovf   <= w_c[SLICE-1] ^ w_c[SLICE];
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;

endmodule
